// File: rtl/lemming_pkg.sv
// lemming_pkg: shared types and constants for the lemming arena environment model.
//   state_e    : arena FSM states (IDLE / RUN / HALT)
//   dir_e      : walk input encoding {walk_left, walk_right}
//   BUMP_CNT_W : width of the saturating bump counter
package lemming_pkg;

    localparam int BUMP_CNT_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_BOTH  = 2'b11
    } dir_e;

endpackage

// File: rtl/lemming_tick_gen.sv
// lemming_tick_gen: movement prescaler, one tick every STEP_DIV enabled cycles.
//   clk, areset_n : clock, asynchronous active-low reset
//   clr           : synchronous clear to 0 (wins over en)
//   en            : count enable
//   tick          : high while the count equals STEP_DIV-1 and en is high
module lemming_tick_gen #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/lemming_arena.sv
// lemming_arena: 1-D track model that turns walker direction into wall bump pulses.
//   clk, areset_n          : clock, asynchronous active-low reset
//   load, start_pos        : load clamped start position and enter RUN (highest priority)
//   walk_left, walk_right  : walker direction, sampled on movement ticks only
//   obstacle_vld/_pos      : optional obstacle, present with LEMMING_ARENA_OBSTACLE_EN
//   bump_left, bump_right  : registered one-cycle wall-hit pulses
//   pos, step              : current position, one-cycle moved pulse
//   bump_count             : saturating bump total since load
//   halted                 : high in HALT (illegal walk encoding seen on a tick)
module lemming_arena
    import lemming_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LEFT_WALL  = 0,
    parameter int RIGHT_WALL = 15,
    parameter int STEP_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      start_pos,
    input  logic                  walk_left,
    input  logic                  walk_right,
`ifdef LEMMING_ARENA_OBSTACLE_EN
    input  logic                  obstacle_vld,
    input  logic [WIDTH-1:0]      obstacle_pos,
`endif
    output logic                  bump_left,
    output logic                  bump_right,
    output logic [WIDTH-1:0]      pos,
    output logic                  step,
    output logic [BUMP_CNT_W-1:0] bump_count,
    output logic                  halted
);

    state_e state, state_nx;
    dir_e   dir;
    logic   tick, go_r, go_l, blk_r, blk_l, bump_r_nx, bump_l_nx, step_nx;
    logic [WIDTH-1:0]      pos_nx, start_clamped;
    logic [BUMP_CNT_W-1:0] cnt_nx;

    assign dir = dir_e'({walk_left, walk_right});

    lemming_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (load || state != RUN),
        .en       (state == RUN),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (load)
            state_nx = RUN;
        else if (tick && (dir == DIR_NONE || dir == DIR_BOTH))
            state_nx = HALT;
    end

    // Wall tests use the current position, so pos never wraps on +1/-1.
    always_comb begin
        start_clamped = int'(start_pos) < LEFT_WALL  ? WIDTH'(LEFT_WALL)  :
                        int'(start_pos) > RIGHT_WALL ? WIDTH'(RIGHT_WALL) : start_pos;
        go_r = tick && !load && dir == DIR_RIGHT;
        go_l = tick && !load && dir == DIR_LEFT;
`ifdef LEMMING_ARENA_OBSTACLE_EN
        blk_r = int'(pos) >= RIGHT_WALL ||
                (obstacle_vld && obstacle_pos != pos && obstacle_pos == pos + WIDTH'(1));
        blk_l = int'(pos) <= LEFT_WALL ||
                (obstacle_vld && obstacle_pos != pos && obstacle_pos == pos - WIDTH'(1));
`else
        blk_r = int'(pos) >= RIGHT_WALL;
        blk_l = int'(pos) <= LEFT_WALL;
`endif
        bump_r_nx = go_r && blk_r;
        bump_l_nx = go_l && blk_l;
        step_nx   = (go_r && !blk_r) || (go_l && !blk_l);
        pos_nx    = load            ? start_clamped   :
                    go_r && !blk_r  ? pos + WIDTH'(1) :
                    go_l && !blk_l  ? pos - WIDTH'(1) : pos;
        cnt_nx    = load ? '0 :
                    (bump_r_nx || bump_l_nx) && bump_count != '1 ? bump_count + BUMP_CNT_W'(1) :
                    bump_count;
        halted    = state == HALT;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos        <= WIDTH'(LEFT_WALL);
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            step       <= 1'b0;
            bump_count <= '0;
        end else begin
            pos        <= pos_nx;
            bump_left  <= bump_l_nx;
            bump_right <= bump_r_nx;
            step       <= step_nx;
            bump_count <= cnt_nx;
        end
    end

endmodule
